// File: rtl/audio_dac_serializer_if.sv
`timescale 1ns/1ps
// Sample-pair handshake between the sound-generation datapath and the DAC serializer.
interface audio_dac_serializer_if;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        write_audio_out;
    logic        clear_audio_out_memory;
    logic        audio_out_allowed;

    modport master (
        output left_channel_audio_out,
        output right_channel_audio_out,
        output write_audio_out,
        output clear_audio_out_memory,
        input  audio_out_allowed
    );

    modport slave (
        input  left_channel_audio_out,
        input  right_channel_audio_out,
        input  write_audio_out,
        input  clear_audio_out_memory,
        output audio_out_allowed
    );
endinterface

// File: rtl/audio_dac_serializer.sv
`timescale 1ns/1ps
// Buffers stereo sample pairs in a FIFO and shifts them out MSB-first in I2S format,
// timed by the codec-mastered bit clock and frame clock.
module audio_dac_serializer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SAMPLE_BITS = 32
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    audio_dac_serializer_if.slave       audio,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
    state_t state, state_next;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [63:0]   rd_word;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    logic [2:0]    bclk_q, lrck_q;
    logic          bclk_fall, lrck_last;
    logic          lrck_fall_ev, lrck_rise_ev;

    logic [31:0]   shift_reg, right_hold;
    logic [CW-1:0] bit_cnt;
    logic          load_left, load_right, shift_bit, pending_bit;

    assign audio.audio_out_allowed = (fifo_level != LW'(FIFO_DEPTH));
    assign push    = audio.write_audio_out && audio.audio_out_allowed;
    assign pop     = load_left && (fifo_level != '0);
    assign rd_word = mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (push && !audio.clear_audio_out_memory)
            mem[wr_ptr] <= {audio.left_channel_audio_out, audio.right_channel_audio_out};
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (audio.clear_audio_out_memory) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // lrck_q[2] lines up with the registered bclk_fall pulse, so frame edges are judged at BCLK falls.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bclk_q    <= '0;
            lrck_q    <= '0;
            bclk_fall <= 1'b0;
            lrck_last <= 1'b0;
        end else begin
            bclk_q    <= {bclk_q[1:0], AUD_BCLK};
            lrck_q    <= {lrck_q[1:0], AUD_DACLRCK};
            bclk_fall <= bclk_q[2] & ~bclk_q[1];
            if (bclk_fall) lrck_last <= lrck_q[2];
        end
    end

    assign lrck_fall_ev = bclk_fall && !lrck_q[2] && lrck_last;
    assign lrck_rise_ev = bclk_fall && lrck_q[2] && !lrck_last;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_left  = 1'b0;
        load_right = 1'b0;
        shift_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (lrck_fall_ev) begin
                    state_next = LEFT;
                    load_left  = 1'b1;
                end
            end
            default: begin
                if (lrck_fall_ev) begin
                    state_next = LEFT;
                    load_left  = 1'b1;
                end else if (lrck_rise_ev) begin
                    state_next = RIGHT;
                    load_right = 1'b1;
                end else if (bclk_fall) begin
                    shift_bit  = 1'b1;
                end
            end
        endcase
    end

    // The BCLK that carries a frame-clock edge still belongs to the previous slot (I2S one-bit delay).
    assign pending_bit = (state != IDLE) && (bit_cnt < CW'(SAMPLE_BITS)) && shift_reg[31];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            shift_reg  <= '0;
            right_hold <= '0;
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
            underflow  <= 1'b0;
        end else if (load_left) begin
            shift_reg  <= pop ? rd_word[63:32] : 32'd0;
            right_hold <= pop ? rd_word[31:0]  : 32'd0;
            bit_cnt    <= '0;
            AUD_DACDAT <= pending_bit;
            if (!pop) underflow <= 1'b1;
        end else if (load_right) begin
            shift_reg  <= right_hold;
            bit_cnt    <= '0;
            AUD_DACDAT <= pending_bit;
        end else if (shift_bit) begin
            if (bit_cnt < CW'(SAMPLE_BITS)) begin
                AUD_DACDAT <= shift_reg[31];
                shift_reg  <= {shift_reg[30:0], 1'b0};
                bit_cnt    <= bit_cnt + CW'(1);
            end else begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
`timescale 1ns/1ps
// Directed bench for audio_dac_serializer: drives BCLK/LRCK as a codec master and
// captures DACDAT on every BCLK rising edge.
module tb_audio_dac_serializer;
    logic        CLOCK_50;
    logic        resetn;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic [4:0]  fifo_level;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    logic        b, prev;
    logic [31:0] capL, capRhi, lastRhi, lastR;
    logic [63:0] acc;

    audio_dac_serializer_if audio ();

    audio_dac_serializer #(.FIFO_DEPTH(16), .SAMPLE_BITS(32)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .audio       (audio),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .fifo_level  (fifo_level),
        .underflow   (underflow)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] fillLeft(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h0010_3005;
    endfunction

    function automatic logic [31:0] fillRight(input int i);
        return 32'h5000_00F0 ^ (32'(i) << 8) ^ 32'(i);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r, input logic clr);
        @(negedge CLOCK_50);
        audio.left_channel_audio_out  = l;
        audio.right_channel_audio_out = r;
        audio.write_audio_out         = 1'b1;
        audio.clear_audio_out_memory  = clr;
        @(negedge CLOCK_50);
        audio.write_audio_out         = 1'b0;
        audio.clear_audio_out_memory  = 1'b0;
    endtask

    // One 16-cycle BCLK period; pushNow raises write on the cycle the serializer acts on this fall.
    task automatic bclkPeriod(input logic lrckVal, input logic pushNow, output logic bitOut);
        @(negedge CLOCK_50);
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = lrckVal;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLOCK_50);
            if (pushNow) audio.write_audio_out = (c == 3);
        end
        AUD_BCLK = 1'b1;
        bitOut   = AUD_DACDAT;
        repeat (7) @(negedge CLOCK_50);
    endtask

    task automatic runFrame(input int leftLen, input int rightLen, input logic pushAtStart,
                            output logic prevLsb, output logic [31:0] cL, output logic [31:0] cRhi);
        logic bit1;
        cL   = '0;
        cRhi = '0;
        bclkPeriod(1'b0, pushAtStart, prevLsb);
        for (int p = 1; p < leftLen; p++) begin
            bclkPeriod(1'b0, 1'b0, bit1);
            cL = {cL[30:0], bit1};
        end
        bclkPeriod(1'b1, 1'b0, bit1);
        cL = {cL[30:0], bit1};
        for (int p = 1; p < rightLen; p++) begin
            bclkPeriod(1'b1, 1'b0, bit1);
            cRhi = {cRhi[30:0], bit1};
        end
    endtask

    initial begin
        resetn      = 1'b0;
        AUD_BCLK    = 1'b1;
        AUD_DACLRCK = 1'b1;
        audio.left_channel_audio_out  = '0;
        audio.right_channel_audio_out = '0;
        audio.write_audio_out         = 1'b0;
        audio.clear_audio_out_memory  = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("rst.dacdat",    AUD_DACDAT, 0);
        checkOutput("rst.allowed",   audio.audio_out_allowed, 1);
        checkOutput("rst.level",     fifo_level, 0);
        checkOutput("rst.underflow", underflow, 0);
        resetn = 1'b1;

        // Start a frame, then pull reset part-way through the left slot.
        applyStimulus(32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'h8765_4321, 1'b0);
        checkOutput("pre.level2", fifo_level, 2);
        bclkPeriod(1'b1, 1'b0, b);
        for (int p = 0; p < 6; p++) bclkPeriod(1'b0, 1'b0, b);
        checkOutput("pre.bit", b, 1);
        checkOutput("pre.level1", fifo_level, 1);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("mid.dacdat",    AUD_DACDAT, 0);
        checkOutput("mid.allowed",   audio.audio_out_allowed, 1);
        checkOutput("mid.level",     fifo_level, 0);
        checkOutput("mid.underflow", underflow, 0);
        resetn = 1'b1;
        acc = '0;
        for (int p = 6; p < 32; p++) begin bclkPeriod(1'b0, 1'b0, b); acc = {acc[62:0], b}; end
        for (int p = 0; p < 32; p++) begin bclkPeriod(1'b1, 1'b0, b); acc = {acc[62:0], b}; end
        checkOutput("post.quiet", acc, 0);
        checkOutput("post.underflow", underflow, 0);

        // Single pair.
        applyStimulus(32'hA5A5_0001, 32'h8000_00FF, 1'b0);
        checkOutput("single.level1", fifo_level, 1);
        runFrame(32, 32, 1'b0, prev, capL, capRhi);
        checkOutput("single.delaybit", prev, 0);
        checkOutput("single.L", capL, 32'hA5A5_0001);
        checkOutput("single.level0", fifo_level, 0);
        lastRhi = capRhi;
        lastR   = 32'h8000_00FF;

        // Fill to full, then one ignored write.
        for (int i = 0; i < 16; i++) applyStimulus(fillLeft(i), fillRight(i), 1'b0);
        checkOutput("fill.level16", fifo_level, 16);
        checkOutput("fill.allowed", audio.audio_out_allowed, 0);
        applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        checkOutput("fill.ignored", fifo_level, 16);
        for (int i = 0; i < 16; i++) begin
            runFrame(32, 32, 1'b0, prev, capL, capRhi);
            checkOutput($sformatf("drain%0d.prevR", i), {capRhi[31], lastRhi[30:0], prev}, {1'b0, lastR});
            checkOutput($sformatf("drain%0d.L", i), capL, fillLeft(i));
            lastRhi = capRhi;
            lastR   = fillRight(i);
        end
        checkOutput("drain.level0", fifo_level, 0);
        checkOutput("drain.allowed", audio.audio_out_allowed, 1);

        // Underflow.
        checkOutput("uf.before", underflow, 0);
        runFrame(32, 32, 1'b0, prev, capL, capRhi);
        checkOutput("uf.prevR", {lastRhi[30:0], prev}, lastR);
        checkOutput("uf.L", capL, 0);
        checkOutput("uf.R", capRhi, 0);
        checkOutput("uf.flag", underflow, 1);
        lastRhi = capRhi;
        lastR   = 32'd0;
        applyStimulus(32'h0F0F_1234, 32'hF0F0_5679, 1'b0);
        checkOutput("uf.sticky", underflow, 1);

        // Push landing on the frame-start pop.
        applyStimulus(32'h2222_0002, 32'h3333_0003, 1'b0);
        applyStimulus(32'h4444_0004, 32'h5555_0005, 1'b0);
        checkOutput("pp.level3", fifo_level, 3);
        audio.left_channel_audio_out  = 32'h6666_0006;
        audio.right_channel_audio_out = 32'h7777_0007;
        runFrame(32, 32, 1'b1, prev, capL, capRhi);
        checkOutput("pp.prevR", {lastRhi[30:0], prev}, lastR);
        checkOutput("pp.L", capL, 32'h0F0F_1234);
        checkOutput("pp.level", fifo_level, 3);
        lastRhi = capRhi;
        lastR   = 32'hF0F0_5679;

        // Clear together with a push.
        applyStimulus(32'h9999_0009, 32'hAAAA_000A, 1'b1);
        checkOutput("clr.level", fifo_level, 0);
        checkOutput("clr.allowed", audio.audio_out_allowed, 1);

        // Short left slot, then normal frames.
        applyStimulus(32'hC3A5_9F17, 32'h8123_4567, 1'b0);
        applyStimulus(32'h1357_9BDF, 32'h2468_ACE1, 1'b0);
        applyStimulus(32'h7E7E_8181, 32'h0000_0001, 1'b0);
        runFrame(20, 32, 1'b0, prev, capL, capRhi);
        checkOutput("short.prevR", {lastRhi[30:0], prev}, lastR);
        checkOutput("short.Lhigh", capL[19:0], 20'hC3A59);
        lastRhi = capRhi;
        lastR   = 32'h8123_4567;
        runFrame(32, 32, 1'b0, prev, capL, capRhi);
        checkOutput("short.R", {lastRhi[30:0], prev}, lastR);
        checkOutput("next1.L", capL, 32'h1357_9BDF);
        lastRhi = capRhi;
        lastR   = 32'h2468_ACE1;
        runFrame(32, 32, 1'b0, prev, capL, capRhi);
        checkOutput("next1.R", {lastRhi[30:0], prev}, lastR);
        checkOutput("next2.L", capL, 32'h7E7E_8181);
        checkOutput("end.level", fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Playback end of the audio-out sample handshake. Accepts stereo sample pairs from the sound-generation logic through the `write_audio_out` / `audio_out_allowed` handshake and buffers them in a FIFO. It serializes them MSB-first onto `AUD_DACDAT` in I2S format, timed by the codec-mastered `AUD_BCLK` and `AUD_DACLRCK`. It sits between the wave/ALU datapath and the WM8731 codec pins, alongside the `avconf` I2C configuration block.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 16: sample-pair entries. Must be a power of 2, at least 2.
- `SAMPLE_BITS`, default 32: bits shifted out per channel slot, taken MSB-first from the 32-bit word.

**Ports**
- `CLOCK_50`, in, 1: the single clock. All logic is on its rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `left_channel_audio_out`, in, 32: left sample, two's complement.
- `right_channel_audio_out`, in, 32: right sample, two's complement.
- `write_audio_out`, in, 1: push request for one L/R pair.
- `clear_audio_out_memory`, in, 1: synchronous FIFO flush.
- `AUD_BCLK`, in, 1: codec bit clock. Asynchronous to `CLOCK_50`.
- `AUD_DACLRCK`, in, 1: codec frame clock. Low selects left, high selects right.
- `audio_out_allowed`, out, 1: FIFO not full.
- `AUD_DACDAT`, out, 1: serial data to the codec.
- `fifo_level`, out, log2(FIFO_DEPTH)+1: entries currently stored.
- `underflow`, out, 1: sticky flag, set when a frame starts with the FIFO empty.

## Operation

**Input handshake**
- A push occurs on a cycle where `write_audio_out && audio_out_allowed`. The pair {left, right} is stored at the write pointer.
- `write_audio_out` while full is ignored. No data is stored and no error is flagged.
- `audio_out_allowed` = (`fifo_level` != FIFO_DEPTH). It is combinational from registered count.

**Clock-domain handling**
- `AUD_BCLK` and `AUD_DACLRCK` each pass through a 2-flop synchronizer.
- Edge detection compares the synchronized value against a third flop.
- `bclk_fall` is a 1-cycle pulse on a synchronized falling edge of BCLK.

**Serializer FSM**
- States are IDLE, LEFT, RIGHT.
- **IDLE** (after reset): wait for a `bclk_fall` on which synchronized LRCK is low and was high at the previous `bclk_fall`. Then perform a frame start.
- **Frame start:**
  - If the FIFO is not empty, pop one pair: load the left word into the shift register and hold the right word in `right_hold`.
  - If the FIFO is empty, load zeros into both and set `underflow`.
  - Set `bit_cnt` = 0 and go to LEFT.
- **LEFT:** the first `bclk_fall` after the frame start drives shift-register MSB onto `AUD_DACDAT`. This gives the I2S one-BCLK delay. Each later `bclk_fall` shifts left by one and increments `bit_cnt`.
  - After SAMPLE_BITS bits, drive 0 until the LRCK rising edge.
- **LRCK rising edge** (seen at a `bclk_fall`): load `right_hold`, set `bit_cnt` = 0, go to RIGHT. RIGHT serializes identically.
- **LRCK falling edge in RIGHT:** perform a frame start again. Pops happen only at left-frame starts, so L/R pairing is never split.

**Simultaneous and boundary events**
- **Push and pop in the same cycle:** level is unchanged, and both pointers advance.
- **Pointers:** modulo FIFO_DEPTH, wrapping naturally. Level range is 0..FIFO_DEPTH.
- **`clear_audio_out_memory`:** pointers and level go to 0 next cycle and take priority over a push or pop in that cycle. The FSM and the current shift word are not affected.
- **LRCK edge earlier than expected** (short frame): the remaining bits are abandoned and the new slot loads normally.
- **`underflow`:** stays set until reset.

## Timing

**Reset values** (while `resetn` = 0, asynchronous):
- `AUD_DACDAT` = 0, `audio_out_allowed` = 1, `fifo_level` = 0, `underflow` = 0.
- FSM = IDLE, pointers = 0, shift register = 0.

**Handshake timing**
- A push is visible in `fifo_level` on the next cycle.
- `audio_out_allowed` falls in the cycle after the push that fills the FIFO.

**Pin-to-output latency**
- A pin BCLK falling edge reaches `bclk_fall` 3 `CLOCK_50` cycles later.
- `AUD_DACDAT` updates registered, 1 cycle after `bclk_fall`.
- Total: 4 cycles (80 ns). This is valid for BCLK periods of at least 8 `CLOCK_50` cycles, e.g. 3.072 MHz.

**Reset mid-operation:** reset asserted mid-frame forces IDLE. After release, no data is output until the next left-frame start.

## Test plan

- **Reset defaults:** assert reset mid-frame → `AUD_DACDAT`=0, `allowed`=1, `level`=0, `underflow`=0. After release, the first serialized bit is no earlier than the next LRCK falling edge.
- **Single-pair serialization:** push L=0xA5A5_0001, R=0x8000_00FF, then run a 64-BCLK frame → the captured DACDAT bits on BCLK rising edges equal L MSB-first, starting one BCLK after the LRCK fall, then R one BCLK after the LRCK rise. `level` 1→0 at the frame start.
- **Fill to full:** push 16 pairs with no BCLK → `level`=16, `allowed`=0. A 17th write is ignored. After 16 frames the data out equals the pushes in order across pointer wrap.
- **Underflow:** run a frame with an empty FIFO → all-zero slots and `underflow`=1, which persists after later pushes.
- **Simultaneous push and pop, plus clear:** push on the exact frame-start cycle with `level`=3 → `level` stays 3. Assert clear with a push in the same cycle → `level`=0.
- **Short frame:** LRCK rises after 20 bits → the right slot starts correctly with its MSB. No pairing slip on subsequent frames.
